// File: rtl/aud_player.sv
// I2S playback transmitter: streams 16-bit SRAM words MSB-first during the LRCK-high half-frame.
// Define AUD_PLAYER_LOOP_EN to wrap from the stop address back to address 0 instead of stopping.
module aud_player (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    input  logic [19:0] i_stop_address,
    input  logic [15:0] i_data,
    output logic [19:0] o_address,
    output logic        o_dacdat,
    output logic        o_playing,
    output logic [2:0]  o_state
);

    localparam int DATA_W = 16;
    localparam int ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4,
        PAUSE = 3'd5,
        STOP  = 3'd6
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic                dac_q, dac_nx;
    logic [DATA_W-2:0]   shift_q, shift_nx;
    logic [4:0]          cnt_q, cnt_nx;
    logic                pflag_q, pflag_nx;
    logic                sflag_q, sflag_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            dac_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            pflag_q <= 1'b0;
            sflag_q <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            dac_q   <= dac_nx;
            shift_q <= shift_nx;
            cnt_q   <= cnt_nx;
            pflag_q <= pflag_nx;
            sflag_q <= sflag_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        dac_nx   = dac_q;
        shift_nx = shift_q;
        cnt_nx   = cnt_q;
        // Requests are latched here and only acted on at word boundaries.
        pflag_nx = pflag_q | (i_pause && !(state inside {IDLE, PAUSE, STOP}));
        sflag_nx = sflag_q | (i_stop && (state != IDLE));

        case (state)
            IDLE: begin
                dac_nx = 1'b0;
                if (i_start) begin
                    state_nx = SYNC;
                    addr_nx  = '0;
                end
            end
            SYNC: begin
                dac_nx = 1'b0;
                if (sflag_q)      state_nx = STOP;
                else if (pflag_q) state_nx = PAUSE;
                else if (!i_lrc)  state_nx = WAIT;
            end
            WAIT: begin
                dac_nx = 1'b0;
                if (sflag_q)      state_nx = STOP;
                else if (pflag_q) state_nx = PAUSE;
                else if (i_lrc) begin
                    state_nx = SEND;
                    dac_nx   = i_data[DATA_W-1];
                    shift_nx = i_data[DATA_W-2:0];
                    cnt_nx   = 5'd1;
                end
            end
            SEND: begin
                if (cnt_q == 5'd16) begin
                    dac_nx = 1'b0;
                    cnt_nx = '0;
                    if (addr_q == i_stop_address) begin
`ifdef AUD_PLAYER_LOOP_EN
                        addr_nx  = '0;
                        state_nx = DONE;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        addr_nx  = addr_q + 20'd1;
                        state_nx = DONE;
                    end
                end else begin
                    dac_nx   = shift_q[DATA_W-2];
                    shift_nx = {shift_q[DATA_W-3:0], 1'b0};
                    cnt_nx   = cnt_q + 5'd1;
                end
            end
            DONE: begin
                dac_nx = 1'b0;
                if (sflag_q)      state_nx = STOP;
                else if (pflag_q) state_nx = PAUSE;
                else if (!i_lrc)  state_nx = WAIT;
            end
            PAUSE: begin
                dac_nx = 1'b0;
                if (i_stop) begin
                    state_nx = STOP;
                end else if (i_start) begin
                    state_nx = SYNC;
                    pflag_nx = 1'b0;
                end
            end
            STOP: begin
                dac_nx   = 1'b0;
                addr_nx  = '0;
                pflag_nx = 1'b0;
                sflag_nx = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                dac_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    assign o_address = addr_q;
    assign o_dacdat  = dac_q;
    assign o_state   = state;
    assign o_playing = (state == SYNC) || (state == WAIT) || (state == SEND) || (state == DONE);

endmodule

// File: tb/tb_aud_player.sv
// Bench for aud_player: drives 64-BCLK LRCK frames and compares serialized words against SRAM contents.
module tb_aud_player;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        lrc = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] stop_addr = '0;
    logic [15:0] data;
    logic [19:0] address;
    logic        dacdat;
    logic        playing;
    logic [2:0]  state;

    logic [15:0] mem [0:63];
    int ph = 0;
    int n_pass = 0;
    int n_total = 0;

    aud_player dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_lrc          (lrc),
        .i_start        (start),
        .i_pause        (pause),
        .i_stop         (stop),
        .i_stop_address (stop_addr),
        .i_data         (data),
        .o_address      (address),
        .o_dacdat       (dacdat),
        .o_playing      (playing),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    // Combinational SRAM model
    assign data = (address < 20'd64) ? mem[address[5:0]] : 16'h0000;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        ph++;
        lrc = (ph % 64) >= 32;
    endtask

    task automatic align(input int target);
        do step(); while ((ph % 64) != target);
    endtask

    task automatic pulse_start(input int target);
        align(target);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Advance to the next LRCK rising edge, noting any activity on the data line meanwhile.
    task automatic wait_rise(output logic noisy);
        noisy = 1'b0;
        do begin
            step();
            if (dacdat !== 1'b0) noisy = 1'b1;
        end while ((ph % 64) != 32);
    endtask

    task automatic capture(input int exp_addr, input logic [15:0] exp_word,
                           input int pulse_at, input int kind, input string tag);
        logic [15:0] got;
        got = '0;
        for (int k = 0; k < 16; k++) begin
            if (k == pulse_at) begin
                pause = (kind == 1);
                stop  = (kind == 2);
                start = (kind == 3);
            end
            step();
            pause = 1'b0;
            stop  = 1'b0;
            start = 1'b0;
            got = {got[14:0], dacdat};
            if (k == 8) begin
                n_total++;
                if (address !== exp_addr[19:0])
                    $display("FAIL %s_addr: got %0d, want %0d", tag, address, exp_addr);
                else n_pass++;
                n_total++;
                if (playing !== 1'b1)
                    $display("FAIL %s_playing: got %b, want 1", tag, playing);
                else n_pass++;
            end
        end
        n_total++;
        if (got !== exp_word)
            $display("FAIL %s_word: got %h, want %h", tag, got, exp_word);
        else n_pass++;
    endtask

    task automatic play_frame(input int exp_addr, input logic [15:0] exp_word,
                              input int pulse_at, input int kind, input string tag);
        logic noisy;
        wait_rise(noisy);
        n_total++;
        if (noisy !== 1'b0) $display("FAIL %s_gap: got activity %b, want 0", tag, noisy);
        else n_pass++;
        capture(exp_addr, exp_word, pulse_at, kind, tag);
    endtask

    task automatic check_idle(input string tag);
        n_total++;
        if (state !== S_IDLE) $display("FAIL %s_state: got %0d, want %0d", tag, state, S_IDLE);
        else n_pass++;
        n_total++;
        if (address !== 20'd0) $display("FAIL %s_addr: got %0d, want 0", tag, address);
        else n_pass++;
        n_total++;
        if (playing !== 1'b0) $display("FAIL %s_playing: got %b, want 0", tag, playing);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        check_idle("reset");
        n_total++;
        if (dacdat !== 1'b0) $display("FAIL reset_dacdat: got %b, want 0", dacdat);
        else n_pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_idle("reset_hold");
    endtask

    task automatic test_playback();
        mem[0] = 16'hA5C3; mem[1] = 16'h8001; mem[2] = 16'h7FFE;
        stop_addr = 20'd2;
        pulse_start(4);
        for (int i = 0; i < 3; i++) play_frame(i, mem[i], -1, 0, "play");
        step();
        n_total++;
        if (state !== S_STOP) $display("FAIL play_stop_state: got %0d, want %0d", state, S_STOP);
        else n_pass++;
        step();
        check_idle("play_end");
    endtask

    task automatic test_start_high();
        logic noisy;
        mem[0] = 16'($urandom) | 16'h8421;
        mem[1] = 16'hFFFF;
        stop_addr = 20'd0;
        pulse_start(int'($urandom_range(33, 58)));
        play_frame(0, mem[0], -1, 0, "high");
        step(); step();
        check_idle("high_end");
        wait_rise(noisy);
        for (int k = 0; k < 20; k++) begin
            step();
            if (dacdat !== 1'b0) noisy = 1'b1;
        end
        n_total++;
        if (noisy !== 1'b0) $display("FAIL high_single_word: got activity %b, want 0", noisy);
        else n_pass++;
    endtask

    task automatic test_random_words();
        logic [15:0] exp_q [$];
        int n;
        int kstart;
        n = int'($urandom_range(2, 5));
        for (int i = 0; i < n; i++) begin
            mem[i] = 16'($urandom);
            exp_q.push_back(mem[i]);
        end
        stop_addr = 20'(n - 1);
        kstart = int'($urandom_range(0, 15));
        pulse_start(int'($urandom_range(0, 28)));
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = exp_q.pop_front();
            play_frame(i, w, (i == 0) ? kstart : -1, 3, "rand");
        end
        step(); step(); step();
        check_idle("rand_end");
    endtask

    task automatic test_pause_resume();
        logic n1, n2;
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        stop_addr = 20'd7;
        pulse_start(int'($urandom_range(0, 28)));
        for (int i = 0; i < 3; i++) play_frame(i, mem[i], -1, 0, "pre_pause");
        play_frame(3, mem[3], 10, 1, "pause_word");
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if (state !== S_PAUSE) $display("FAIL pause_state: got %0d, want %0d", state, S_PAUSE);
        else n_pass++;
        n_total++;
        if (address !== 20'd4) $display("FAIL pause_addr: got %0d, want 4", address);
        else n_pass++;
        n_total++;
        if (dacdat !== 1'b0 || playing !== 1'b0)
            $display("FAIL pause_outputs: got dacdat=%b playing=%b, want 0 0", dacdat, playing);
        else n_pass++;
        wait_rise(n1);
        wait_rise(n2);
        n_total++;
        if (n1 !== 1'b0 || n2 !== 1'b0 || state !== S_PAUSE)
            $display("FAIL pause_hold: got activity %b%b state %0d, want 00 %0d", n1, n2, state, S_PAUSE);
        else n_pass++;
        pulse_start(int'($urandom_range(0, 28)));
        play_frame(4, mem[4], -1, 0, "resume");
        play_frame(5, mem[5], int'($urandom_range(0, 15)), 1, "pause2");
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if (state !== S_PAUSE || address !== 20'd6)
            $display("FAIL pause2: got state %0d addr %0d, want %0d 6", state, address, S_PAUSE);
        else n_pass++;
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        n_total++;
        if (state !== S_STOP) $display("FAIL pause_stop_start: got %0d, want %0d", state, S_STOP);
        else n_pass++;
        step();
        check_idle("pause_stop_end");
    endtask

    task automatic test_stop_flag();
        for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
        stop_addr = 20'd10;
        pulse_start(int'($urandom_range(0, 28)));
        play_frame(0, mem[0], -1, 0, "sflag0");
        play_frame(1, mem[1], int'($urandom_range(0, 15)), 2, "sflag1");
        step(); step();
        n_total++;
        if (state !== S_STOP) $display("FAIL sflag_state: got %0d, want %0d", state, S_STOP);
        else n_pass++;
        step();
        check_idle("sflag_end");
    endtask

    task automatic test_async_reset();
        mem[0] = 16'($urandom);
        mem[1] = 16'hFFFF;
        stop_addr = 20'd5;
        pulse_start(int'($urandom_range(0, 28)));
        play_frame(0, mem[0], -1, 0, "arst0");
        begin
            logic noisy;
            wait_rise(noisy);
        end
        for (int k = 0; k < 8; k++) step();
        n_total++;
        if (dacdat !== 1'b1 || state !== S_SEND || address !== 20'd1)
            $display("FAIL arst_pre: got dacdat=%b state=%0d addr=%0d, want 1 %0d 1", dacdat, state, address, S_SEND);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (dacdat !== 1'b0) $display("FAIL arst_dacdat: got %b, want 0", dacdat);
        else n_pass++;
        check_idle("arst");
        step();
        rst_n = 1'b1;
        begin
            logic act;
            act = 1'b0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (dacdat !== 1'b0 || state !== S_IDLE) act = 1'b1;
            end
            n_total++;
            if (act !== 1'b0) $display("FAIL arst_no_resume: got activity %b, want 0", act);
            else n_pass++;
        end
    endtask

    task automatic test_loop();
        mem[0] = 16'($urandom);
        mem[1] = 16'($urandom);
        stop_addr = 20'd1;
        pulse_start(int'($urandom_range(0, 28)));
`ifdef AUD_PLAYER_LOOP_EN
        for (int i = 0; i < 4; i++) play_frame(i % 2, mem[i % 2], -1, 0, "loop");
        play_frame(0, mem[0], 3, 2, "loop_stop");
        step(); step(); step();
        check_idle("loop_end");
`else
        for (int i = 0; i < 2; i++) play_frame(i, mem[i], -1, 0, "noloop");
        step(); step();
        check_idle("noloop_end");
        begin
            logic noisy;
            wait_rise(noisy);
            for (int k = 0; k < 20; k++) begin
                step();
                if (dacdat !== 1'b0) noisy = 1'b1;
            end
            n_total++;
            if (noisy !== 1'b0) $display("FAIL noloop_quiet: got activity %b, want 0", noisy);
            else n_pass++;
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_playback();
        test_start_high();
        test_random_words();
        test_pause_resume();
        test_stop_flag();
        test_async_reset();
        test_loop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aud_player.md
# aud_player

I2S playback transmitter for the WM8731 DAC path: the counterpart of the recording path. It fetches 16-bit samples from audio SRAM by address, serializes each word MSB-first on the DAC data line during the right-channel (LRCK high) half-frame, and advances through memory until it reaches the stop address supplied by the recording path. Start, pause and stop come from the same top-level button controller that drives recording. It runs entirely in the codec bit-clock domain.

## Interface
Parameters: none.
- i_clk  input  1  codec bit clock (AUD_BCLK); all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_lrc  input  1  AUD_DACLRCK; high = right channel (the only channel driven)
- i_start  input  1  start / resume pulse
- i_pause  input  1  pause pulse
- i_stop  input  1  stop pulse
- i_stop_address  input  20  last valid sample address (inclusive)
- i_data  input  16  SRAM read data for o_address (combinational read)
- o_address  output  20  current SRAM word address
- o_dacdat  output  1  I2S serial data to AUD_DACDAT
- o_playing  output  1  high in SYNC, WAIT, SEND, DONE
- o_state  output  3  state code, for debug display

## Operation
- States (o_state): IDLE=0, SYNC=1, WAIT=2, SEND=3, DONE=4, PAUSE=5, STOP=6.
- Reset: state IDLE, o_address=0, o_dacdat=0, shift register 0, bit counter 0, pause/stop flags 0; o_playing=0.
- IDLE: i_start -> SYNC, o_address<=0. All else ignored.
- SYNC: wait for i_lrc low -> WAIT. Prevents starting mid right half.
- WAIT: i_lrc high -> SEND; same edge loads o_dacdat<=i_data[15], shift<=i_data[14:0], counter<=1.
- SEND: each edge o_dacdat<=next shift bit, counter++. Always completes all 16 bits regardless of i_lrc, pause or stop.
- End of word (edge after bit 0 driven): o_dacdat<=0; if o_address==i_stop_address -> STOP; else o_address<=o_address+1, -> DONE.
- DONE: o_dacdat held 0; i_lrc low -> WAIT.
- Pause/stop flags: i_pause sets pause flag in any state except IDLE/PAUSE/STOP; i_stop sets stop flag in any state except IDLE; both cleared in STOP; pause flag cleared on resume.
- Flags act only in SYNC, WAIT, DONE (word boundaries): stop flag -> STOP (priority), else pause flag -> PAUSE.
- PAUSE: o_address held, o_dacdat 0. i_stop -> STOP (same cycle priority over i_start); i_start -> SYNC.
- STOP: one cycle; o_address<=0, flags cleared; -> IDLE.
- i_start while playing: ignored. i_stop_address=0: exactly one word played.
- o_playing and o_state are combinational decodes of the state register.

## Timing
- o_dacdat is registered. MSB appears at the rising edge at which WAIT samples i_lrc=1; bit 15-k is valid for the cycle following edge k, k=0..15.
- o_address must be stable for the whole of WAIT and at the load edge. It changes only at end of word, in IDLE->SYNC, and in STOP.
- i_data must be valid by the load edge (combinational SRAM read, one-cycle path from o_address).
- Word cadence: one word per LRCK frame. Requires at least 17 bit clocks in the right half.
- Mid-operation reset: asynchronous return to reset values. No partial word is completed.

## Configuration
- AUD_PLAYER_LOOP_EN defined: at end of word with o_address==i_stop_address, o_address<=0 and state -> DONE. Playback repeats until i_stop or i_pause.
- AUD_PLAYER_LOOP_EN undefined: that condition goes to STOP as described above.

## Test plan
- Reset, start, stop_address=2, SRAM {0xA5C3,0x8001,0x7FFE}, 64-BCLK frames: o_dacdat shows 1010010111000011, 1000000000000001, 0111111111111110 in three consecutive right halves. Then STOP, IDLE, o_address=0.
- Start asserted while i_lrc high: no bits emitted until the next rising i_lrc. The first word starts at its MSB.
- Pause pulse mid-word (bit 5 of address 3): word 3 completes, o_address=4, state PAUSE, o_dacdat=0. i_start resumes at address 4 after the next low->high LRCK.
- i_stop and i_start in the same cycle while in PAUSE: STOP then IDLE, o_address=0.
- Async reset during SEND at bit 8: o_dacdat=0, o_address=0, o_state=0 immediately, without waiting for a clock edge.
- With AUD_PLAYER_LOOP_EN, stop_address=1: address sequence 0,1,0,1,... with no IDLE until i_stop. Without the macro: sequence 0,1, then IDLE.
